// File: rtl/prefetch_issue_q.sv
// Prefetch issue queue: circular buffer of filtered prefetch candidates issued to memory
// under an outstanding cap. Define PFQ_DROP_STATS_EN to enable the full-queue drop counter.
module prefetch_issue_q #(
    parameter int DEPTH_LOG2 = 2,
    parameter int MAX_OUT    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pf_v,
    input  logic [15:0]           pf_addr,
    input  logic                  demand_v,
    input  logic [15:0]           demand_addr,
    output logic                  mem_v,
    output logic [15:0]           mem_addr,
    input  logic                  mem_ready,
    input  logic                  mem_resp_v,
    output logic [DEPTH_LOG2:0]   count,
    output logic [15:0]           drop_cnt
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int OUT_W = $clog2(MAX_OUT + 1);
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [OUT_W-1:0]    OUT_MAX  = OUT_W'(MAX_OUT);

    logic [DEPTH-1:0]      slot_v_q, slot_v_d;
    logic [15:0]           slot_addr_q [DEPTH];
    logic [15:0]           slot_addr_d [DEPTH];
    logic [DEPTH_LOG2-1:0] head_q, head_d, tail_q, tail_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [OUT_W-1:0]      out_q, out_d;
    logic                  head_v, fire, skip, pop, full, dup_hit, demand_hit, enq;

    always_comb begin
        head_v     = slot_v_q[head_q];
        mem_v      = (count_q != '0) && head_v && (out_q < OUT_MAX);
        mem_addr   = mem_v ? slot_addr_q[head_q] : 16'h0;
        fire       = mem_v && mem_ready;
        skip       = (count_q != '0) && !head_v;
        pop        = fire || skip;
        full       = (count_q == FULL_CNT);
        demand_hit = demand_v && (demand_addr == pf_addr);
        dup_hit    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_v_q[i] && (slot_addr_q[i] == pf_addr)) begin
                dup_hit = 1'b1;
            end
        end
        enq = pf_v && !full && !dup_hit && !demand_hit;
    end

    // A demand that hits the head slot while it is handing off loses to the issue.
    always_comb begin
        slot_v_d    = slot_v_q;
        slot_addr_d = slot_addr_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        out_d       = out_q;
        if (demand_v) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (slot_v_q[i] && (slot_addr_q[i] == demand_addr) &&
                    !(fire && (head_q == DEPTH_LOG2'(i)))) begin
                    slot_v_d[i] = 1'b0;
                end
            end
        end
        if (pop) begin
            slot_v_d[head_q] = 1'b0;
            head_d           = head_q + 1'b1;
        end
        if (enq) begin
            slot_v_d[tail_q]    = 1'b1;
            slot_addr_d[tail_q] = pf_addr;
            tail_d              = tail_q + 1'b1;
        end
        case ({enq, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (fire && !mem_resp_v) begin
            out_d = out_q + 1'b1;
        end else if (!fire && mem_resp_v && (out_q != '0)) begin
            out_d = out_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_v_q <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            out_q    <= '0;
        end else begin
            slot_v_q <= slot_v_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            out_q    <= out_d;
        end
    end

    // Address payload needs no reset; it is only observed behind a set valid bit.
    always_ff @(posedge clk) begin
        slot_addr_q <= slot_addr_d;
    end

    assign count = count_q;

`ifdef PFQ_DROP_STATS_EN
    logic [15:0] drop_q, drop_d;

    always_comb begin
        drop_d = drop_q;
        if (pf_v && full && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = 16'h0;
`endif

endmodule

// File: doc/prefetch_issue_q.md
Name: prefetch_issue_q

Overview:
- Sits directly downstream of the ISB prefetcher and consumes its prefetch_v/prefetch_addr stream.
- Buffers up to 2**DEPTH_LOG2 candidate prefetch addresses in a circular queue.
- Filters duplicates and cancels candidates already hit by demand accesses.
- Issues the survivors to memory over a valid/ready handshake, with a cap on outstanding prefetches.

Parameters:
DEPTH_LOG2, 2, log2 of queue depth (4 slots)
MAX_OUT, 2, max issued-but-uncompleted prefetches (1..7)

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous, active-high reset
pf_v  in  1  prefetch candidate valid (from ISB prefetch_v)
pf_addr  in  16  prefetch candidate address
demand_v  in  1  demand access valid (same stream as ISB v_in)
demand_addr  in  16  demand access address
mem_v  out  1  prefetch request valid to memory
mem_addr  out  16  prefetch request address
mem_ready  in  1  memory accepts request this cycle
mem_resp_v  in  1  one outstanding prefetch completed
count  out  DEPTH_LOG2+1  occupied slots, including cancelled ones
drop_cnt  out  16  prefetches dropped because the queue was full (see Optional Feature)

Behaviour:
- Reset: clk and rst only. All slot valid bits, head, tail, count, outstanding counter and drop_cnt are cleared to 0. mem_v=0; mem_addr=0 while mem_v=0. Reset mid-operation discards queued entries and the outstanding count; any later mem_resp_v with outstanding==0 is ignored.
- Slot state: {v, addr[15:0]}. head and tail are DEPTH_LOG2 bits and wrap modulo depth. count is registered.
- Enqueue: on posedge with pf_v=1 the candidate is written at tail, tail+1, count+1, unless one of these holds:
  - (a) count==depth. The full check uses the registered count; a pop in the same cycle does not make room. The candidate is dropped and counted in drop_cnt.
  - (b) pf_addr equals addr of any slot with v=1. Silent drop.
  - (c) demand_v=1 and demand_addr==pf_addr in the same cycle. Silent drop.
- Cancel: on demand_v=1, every slot with v=1 and addr==demand_addr has its v cleared. The slot stays occupied until it reaches head.
  - Exception: if that slot is head and the handshake mem_v&&mem_ready fires this cycle, the issue wins.
- Issue: mem_v = (count!=0) && slot[head].v && (outstanding<MAX_OUT). This is combinational from registered state, so latency from accepted pf_v to mem_v is 1 cycle. mem_addr = slot[head].addr.
- Pop:
  - When mem_v&&mem_ready: head+1, count-1, outstanding+1.
  - When count!=0 and slot[head].v==0: skip the cancelled slot, head+1, count-1, no issue. One skip per cycle.
  - A simultaneous enqueue and pop leaves count unchanged.
- Holding: mem_v and mem_addr are held stable until mem_ready, except when a demand cancels head. Head cancel deasserts mem_v the next cycle.
- Outstanding counter: width clog2(MAX_OUT+1).
  - Increment on handshake, decrement on mem_resp_v.
  - Both in the same cycle: unchanged.
  - Decrement is clamped at 0.

Optional Feature:
- Macro PFQ_DROP_STATS_EN.
- Defined: drop_cnt increments by 1 on each full-queue drop (case a only) and saturates at 16'hFFFF. It is cleared by rst.
- Not defined: drop_cnt is tied to 16'h0 and no counter register is synthesized. All other behaviour is identical.

Test Plan:
- Basic issue:
  - Stimulus: reset; pf_v with pf_addr=16'h0040 for 1 cycle; mem_ready=1.
  - Response: mem_v=1 with mem_addr=16'h0040 on the next cycle; count returns 0 after the handshake; outstanding=1.
- Full and drop:
  - Stimulus: mem_ready=0; enqueue 16'h0010, 0011, 0012, 0013, then 0014 while count==4.
  - Response: 0014 dropped; drop_cnt=1 with PFQ_DROP_STATS_EN, 0 without; then mem_ready=1 issues 0010..0013 in order.
- Duplicate and same-cycle demand:
  - Stimulus 1: queue holds 16'h0020; pf_addr=16'h0020.
  - Response 1: count stays 1.
  - Stimulus 2: pf_addr=16'h0021 with demand_addr=16'h0021 in the same cycle.
  - Response 2: not enqueued.
- Cancel and skip:
  - Stimulus: mem_ready=0; queue 16'h0030, 0031, 0032; demand_addr=16'h0031; then mem_ready=1.
  - Response: issues 0030, one skip cycle with mem_v=0, then 0032; count ends at 0.
- Outstanding cap:
  - Stimulus: MAX_OUT=2; mem_ready=1; queue 3 entries; no mem_resp_v.
  - Response: two issues, then mem_v=0 with the third held; a single mem_resp_v pulse issues the third on the following cycle.
- Reset mid-operation:
  - Stimulus: rst asserted with count=3 and outstanding=2.
  - Response: next cycle count=0, mem_v=0; a subsequent mem_resp_v leaves outstanding=0.
